alu_op_sequencer: RTL

//  Sequences the shared 4-bit adder datapath (control + adder_4bit) to execute ADD, SUB and MUL.
//  ADD and SUB take one adder pass. MUL takes W shift-add passes through the same adder.

---
 rtl/alu_op_sequencer_if.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bus between the operation sequencer and its environment.
// Purpose: bundles the request side (start/op/operands), the status and
//   result side, and the shared adder datapath drive/return into one bundle.
// Signals:
//   start, op, a, b      request from the switches/start button
//   alu_a, alu_b         adder operands (alu_b passes through the control block)
//   alu_sel, alu_cin     control-block select {s1,s0} and adder carry-in
//   alu_sum, alu_cout    combinational return from the adder
//   busy, done, result   status and registered result
//   neg, err             SUB borrow flag, reserved-op flag
// Modports:
//   slave  - the sequencer itself
//   master - the environment (requester plus adder datapath)
interface alu_op_sequencer_if #(
  parameter int W = 4
);
  logic             start;
  logic [1:0]       op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [1:0]       alu_sel;
  logic             alu_cin;
  logic [W-1:0]     alu_sum;
  logic             alu_cout;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   result;
  logic             neg;
  logic             err;

  modport slave (
    input  start, op, a, b, alu_sum, alu_cout,
    output alu_a, alu_b, alu_sel, alu_cin, busy, done, result, neg, err
  );

  modport master (
    output start, op, a, b, alu_sum, alu_cout,
    input  alu_a, alu_b, alu_sel, alu_cin, busy, done, result, neg, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one shared W-bit adder to execute ADD, SUB and unsigned MUL.
// ADD/SUB use a single adder pass; MUL uses W shift-add passes.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (aborts any operation, no done)
//   bus  - alu_op_sequencer_if.slave: request, adder drive/return, status
// Outputs are driven from registers or from the state decode only; the
// adder return is only ever captured into registers.
module alu_op_sequencer #(
  parameter int         W       = 4,
  parameter logic [1:0] SEL_ADD = 2'b00,
  parameter logic [1:0] SEL_SUB = 2'b11
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mq_q, mq_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  result_q, result_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;

  // Next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    err_d    = err_q;

    case (state_q)
      // FIN accepts a new request too, so a start in the done cycle is not lost.
      S_IDLE, S_FIN: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          op_d  = bus.op;
          err_d = (bus.op == 2'b11);
          case (bus.op)
            OP_ADD, OP_SUB: state_d = S_EXEC;
            OP_MUL: begin
              state_d = S_MUL;
              acc_d   = '0;
              mq_d    = bus.b;
              cnt_d   = '0;
            end
            default: state_d = S_FIN;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_EXEC: begin
        if (op_q == OP_SUB) begin
          // Two's-complement subtract: carry-out set means no borrow.
          result_d = {{W{1'b0}}, bus.alu_sum};
          neg_d    = ~bus.alu_cout;
        end else begin
          result_d = {{(W-1){1'b0}}, bus.alu_cout, bus.alu_sum};
          neg_d    = 1'b0;
        end
        state_d = S_FIN;
      end

      S_MUL: begin
        // {carry, sum, mq} shifted right by one: the low sum bit becomes the
        // next product bit and enters mq from the top.
        acc_d = {bus.alu_cout, bus.alu_sum[W-1:1]};
        mq_d  = {bus.alu_sum[0], mq_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          result_d = {acc_d, mq_d};
          neg_d    = 1'b0;
          state_d  = S_FIN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  // Adder drive and status from state decode; idle drive equals reset values.
  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_sel = SEL_ADD;
    bus.alu_cin = 1'b0;
    case (state_q)
      S_EXEC: begin
        bus.alu_a = a_q;
        bus.alu_b = b_q;
        if (op_q == OP_SUB) begin
          bus.alu_sel = SEL_SUB;
          bus.alu_cin = 1'b1;
        end
      end
      S_MUL: begin
        bus.alu_a = acc_q;
        bus.alu_b = mq_q[0] ? a_q : '0;
      end
      default: ;
    endcase
  end

  assign bus.busy   = (state_q == S_EXEC) || (state_q == S_MUL);
  assign bus.done   = (state_q == S_FIN);
  assign bus.result = result_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;

endmodule
